// File: rtl/alpha_row_serializer.sv
// alpha_row_serializer
// Consumer side of the alphanumeric character ROM. Pulls character bytes
// from video RAM over a single-outstanding request/valid handshake, holds
// one character ahead of the shifter, tracks the scanline inside the
// 12-line character cell, presents code/row to the ROM and serializes the
// returned glyph row MSB first, one pixel per PixelEn.
//
// Build option: define ALPHA_INVERSE_EN to honour VData[6] as an inverse
// video bit (whole 8-bit cell row inverted). Without it VData[6] is ignored
// and no inversion logic exists.
module alpha_row_serializer #(
    parameter int CHARS_PER_LINE = 32,
    parameter int CELL_ROWS      = 12,
    parameter int GLYPH_FIRST    = 3,
    parameter int GLYPH_ROWS     = 7
) (
    input  logic       Clk_i,
    input  logic       Reset_i,
    input  logic       FrameStart_i,
    input  logic       LineStart_i,
    input  logic       PixelEn_i,
    output logic       FetchReq_o,
    input  logic       VDataValid_i,
    input  logic [7:0] VData_i,
    output logic [5:0] RomData_o,
    output logic [3:0] RomRow_o,
    input  logic [7:0] RomAData_i,
    output logic       Pixel_o,
    output logic       Underrun_o
);

    localparam int LW = 4;
    localparam int CW = $clog2(CHARS_PER_LINE + 1);

    localparam logic [LW-1:0] LINE_LAST = LW'(CELL_ROWS - 1);
    localparam logic [LW-1:0] WIN_LO    = LW'(GLYPH_FIRST);
    localparam logic [LW-1:0] WIN_HI    = LW'(GLYPH_FIRST + GLYPH_ROWS);
    localparam logic [CW-1:0] CPL       = CW'(CHARS_PER_LINE);

    // Scanline position inside the character cell
    logic [LW-1:0] line_q, line_d;
    logic [3:0]    rom_row_q, rom_row_d;

    // Shifter and its bit position; 7 means "next PixelEn loads a new cell"
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_q, bit_d;

    // Cells consumed by the shifter and fetches issued on this line
    logic [CW-1:0] cell_q, cell_d;
    logic [CW-1:0] issued_q, issued_d;

    // One-character holding register between VRAM and the shifter
    logic          hold_full_q, hold_full_d;
    logic [5:0]    hold_code_q, hold_code_d;

    // Handshake state and sticky error flag
    logic          req_q, req_d;
    logic          fetch_q, fetch_d;
    logic          underrun_q, underrun_d;

    logic [7:0]    glyph;

`ifdef ALPHA_INVERSE_EN
    logic          hold_inv_q, hold_inv_d;
    logic          unused_vdata;
    assign unused_vdata = VData_i[7];
`else
    logic [1:0]    unused_vdata;
    assign unused_vdata = VData_i[7:6];
`endif

    function automatic logic in_window(input logic [LW-1:0] l);
        return (l >= WIN_LO) && (l < WIN_HI);
    endfunction

    // Row byte that a cell load would put into the shifter this cycle.
    // Lines outside the glyph window are blank before any inversion.
    always_comb begin
        glyph = in_window(line_q) ? RomAData_i : 8'h00;
`ifdef ALPHA_INVERSE_EN
        if (hold_inv_q) begin
            glyph = ~glyph;
        end
`endif
    end

    // Next-state logic: line tracking, VRAM handshake, cell loads, shifting
    always_comb begin
        line_d      = line_q;
        shift_d     = shift_q;
        bit_d       = bit_q;
        cell_d      = cell_q;
        issued_d    = issued_q;
        hold_full_d = hold_full_q;
        hold_code_d = hold_code_q;
        req_d       = req_q;
        fetch_d     = 1'b0;
        underrun_d  = underrun_q;
`ifdef ALPHA_INVERSE_EN
        hold_inv_d  = hold_inv_q;
`endif

        // FrameStart overrides a coincident LineStart
        if (FrameStart_i) begin
            line_d = '0;
        end else if (LineStart_i) begin
            line_d = (line_q == LINE_LAST) ? '0 : line_q + 1'b1;
        end

        if (LineStart_i) begin
            // Fresh line: drop everything in flight, including any data
            // returning this cycle, and start the first fetch right away.
            shift_d     = 8'h00;
            bit_d       = 3'd7;
            cell_d      = '0;
            hold_full_d = 1'b0;
            req_d       = 1'b1;
            fetch_d     = 1'b1;
            issued_d    = CW'(1);
        end else begin
            // Data return; an outstanding request implies the holder is empty
            if (VDataValid_i && req_q) begin
                hold_full_d = 1'b1;
                hold_code_d = VData_i[5:0];
`ifdef ALPHA_INVERSE_EN
                hold_inv_d  = VData_i[6];
`endif
                req_d       = 1'b0;
            end

            if (PixelEn_i) begin
                if (bit_q == 3'd7) begin
                    bit_d = 3'd0;
                    if (hold_full_q) begin
                        shift_d     = glyph;
                        hold_full_d = 1'b0;
                        cell_d      = cell_q + 1'b1;
                    end else if (cell_q < CPL) begin
                        // Character was due but VRAM had not delivered it
                        shift_d    = 8'h00;
                        underrun_d = 1'b1;
                    end else begin
                        // Right border after the last cell
                        shift_d = 8'h00;
                    end
                end else begin
                    shift_d = {shift_q[6:0], 1'b0};
                    bit_d   = bit_q + 1'b1;
                end
            end

            // Refill the holder as soon as it is empty and idle
            if (!hold_full_q && !req_q && (issued_q < CPL)) begin
                req_d    = 1'b1;
                fetch_d  = 1'b1;
                issued_d = issued_q + 1'b1;
            end
        end

        rom_row_d = in_window(line_d) ? 4'(line_d - WIN_LO) : 4'd0;
    end

    // State registers with synchronous reset
    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            line_q      <= '0;
            rom_row_q   <= '0;
            shift_q     <= 8'h00;
            bit_q       <= 3'd7;
            cell_q      <= '0;
            issued_q    <= '0;
            hold_full_q <= 1'b0;
            hold_code_q <= 6'd0;
            req_q       <= 1'b0;
            fetch_q     <= 1'b0;
            underrun_q  <= 1'b0;
`ifdef ALPHA_INVERSE_EN
            hold_inv_q  <= 1'b0;
`endif
        end else begin
            line_q      <= line_d;
            rom_row_q   <= rom_row_d;
            shift_q     <= shift_d;
            bit_q       <= bit_d;
            cell_q      <= cell_d;
            issued_q    <= issued_d;
            hold_full_q <= hold_full_d;
            hold_code_q <= hold_code_d;
            req_q       <= req_d;
            fetch_q     <= fetch_d;
            underrun_q  <= underrun_d;
`ifdef ALPHA_INVERSE_EN
            hold_inv_q  <= hold_inv_d;
`endif
        end
    end

    assign FetchReq_o = fetch_q;
    assign RomData_o  = hold_code_q;
    assign RomRow_o   = rom_row_q;
    assign Pixel_o    = shift_q[7];
    assign Underrun_o = underrun_q;

endmodule

// File: tb/tb_alpha_row_serializer.sv
// Directed bench for alpha_row_serializer with a tiny character ROM model.
module tb_alpha_row_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1, fs = 1'b0, ls = 1'b0, pen = 1'b0, vdv = 1'b0;
    logic [7:0] vdata = 8'h00;
    logic [7:0] romadata;
    logic       fetch, pix, underrun;
    logic [5:0] romcode;
    logic [3:0] romrow;

    int checks = 0;
    int errors = 0;

`ifdef ALPHA_INVERSE_EN
    localparam logic [7:0] EXP_INV_L3 = 8'hF7;
    localparam logic [7:0] EXP_INV_L0 = 8'hFF;
`else
    localparam logic [7:0] EXP_INV_L3 = 8'h08;
    localparam logic [7:0] EXP_INV_L0 = 8'h00;
`endif

    always #5 clk = ~clk;

    // ROM model: code 1 -> 0x08, code 2 -> 0x3C, others blank
    always_comb begin
        case (romcode)
            6'h01:   romadata = 8'h08;
            6'h02:   romadata = 8'h3C;
            default: romadata = 8'h00;
        endcase
    end

    alpha_row_serializer dut (
        .Clk_i(clk), .Reset_i(rst), .FrameStart_i(fs), .LineStart_i(ls),
        .PixelEn_i(pen), .FetchReq_o(fetch), .VDataValid_i(vdv), .VData_i(vdata),
        .RomData_o(romcode), .RomRow_o(romrow), .RomAData_i(romadata),
        .Pixel_o(pix), .Underrun_o(underrun)
    );

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; fs = 1'b0; ls = 1'b0; pen = 1'b0; vdv = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse_fs();
        fs = 1'b1; tick(); fs = 1'b0;
    endtask

    task automatic pulse_ls(input int n);
        for (int i = 0; i < n; i++) begin
            ls = 1'b1; tick(); ls = 1'b0;
        end
    endtask

    task automatic serve(input logic [7:0] code);
        vdata = code; vdv = 1'b1; tick(); vdv = 1'b0;
    endtask

    task automatic grab(output logic [7:0] b);
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            pen = 1'b1; tick(); b = {b[6:0], pix};
        end
        pen = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ls = 1'b1; pen = 1'b1;
        tick();
        ls = 1'b0; pen = 1'b0;
        checks++; if (fetch !== 1'b0) begin errors++; $display("FAIL rst_fetch got %b exp 0", fetch); end
        checks++; if (pix !== 1'b0) begin errors++; $display("FAIL rst_pixel got %b exp 0", pix); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL rst_underrun got %b exp 0", underrun); end
        checks++; if (romcode !== 6'h00) begin errors++; $display("FAIL rst_romdata got %h exp 00", romcode); end
        checks++; if (romrow !== 4'h0) begin errors++; $display("FAIL rst_romrow got %h exp 0", romrow); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] b;
        do_reset(); pulse_fs(); pulse_ls(3);
        checks++; if (fetch !== 1'b1) begin errors++; $display("FAIL basic_fetch got %b exp 1", fetch); end
        checks++; if (romrow !== 4'd0) begin errors++; $display("FAIL basic_row3 got %0d exp 0", romrow); end
        serve(8'h01);
        checks++; if (romcode !== 6'h01) begin errors++; $display("FAIL basic_code got %h exp 01", romcode); end
        grab(b);
        checks++; if (b !== 8'h08) begin errors++; $display("FAIL basic_cell got %h exp 08", b); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL basic_underrun got %b exp 0", underrun); end
        pulse_ls(1);
        checks++; if (romrow !== 4'd1) begin errors++; $display("FAIL basic_row4 got %0d exp 1", romrow); end
        serve(8'h02); grab(b);
        checks++; if (b !== 8'h3C) begin errors++; $display("FAIL basic_cell2 got %h exp 3c", b); end
    endtask

    task automatic test_inverse();
        logic [7:0] b;
        do_reset(); pulse_fs(); pulse_ls(3);
        serve(8'h41);
        checks++; if (romcode !== 6'h01) begin errors++; $display("FAIL inv_code got %h exp 01", romcode); end
        grab(b);
        checks++; if (b !== EXP_INV_L3) begin errors++; $display("FAIL inv_line3 got %h exp %h", b, EXP_INV_L3); end
        fs = 1'b1; ls = 1'b1; tick(); fs = 1'b0; ls = 1'b0;
        serve(8'h41); grab(b);
        checks++; if (b !== EXP_INV_L0) begin errors++; $display("FAIL inv_line0 got %h exp %h", b, EXP_INV_L0); end
    endtask

    task automatic test_wrap();
        logic [7:0] b;
        do_reset(); pulse_fs(); pulse_ls(9);
        checks++; if (romrow !== 4'd6) begin errors++; $display("FAIL wrap_row9 got %0d exp 6", romrow); end
        serve(8'h02); grab(b);
        checks++; if (b !== 8'h3C) begin errors++; $display("FAIL wrap_cell9 got %h exp 3c", b); end
        pulse_ls(1);
        serve(8'h02); grab(b);
        checks++; if (b !== 8'h00) begin errors++; $display("FAIL wrap_cell10 got %h exp 00", b); end
        pulse_ls(2);
        checks++; if (romrow !== 4'd0) begin errors++; $display("FAIL wrap_row0 got %0d exp 0", romrow); end
        serve(8'h01); grab(b);
        checks++; if (b !== 8'h00) begin errors++; $display("FAIL wrap_cell0 got %h exp 00", b); end
        pulse_ls(4);
        checks++; if (romrow !== 4'd1) begin errors++; $display("FAIL wrap_row4 got %0d exp 1", romrow); end
        fs = 1'b1; ls = 1'b1; tick(); fs = 1'b0; ls = 1'b0;
        pulse_ls(4);
        checks++; if (romrow !== 4'd1) begin errors++; $display("FAIL fs_ls_row got %0d exp 1", romrow); end
    endtask

    task automatic test_underrun();
        logic [7:0] b;
        do_reset(); pulse_fs(); pulse_ls(3);
        checks++; if (fetch !== 1'b1) begin errors++; $display("FAIL ur_fetch got %b exp 1", fetch); end
        grab(b);
        checks++; if (b !== 8'h00) begin errors++; $display("FAIL ur_cell got %h exp 00", b); end
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ur_flag got %b exp 1", underrun); end
        serve(8'h01); grab(b);
        checks++; if (b !== 8'h08) begin errors++; $display("FAIL ur_late_cell got %h exp 08", b); end
        pulse_ls(1);
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ur_sticky got %b exp 1", underrun); end
        do_reset();
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ur_reset got %b exp 0", underrun); end
    endtask

    task automatic test_full_line();
        logic [7:0] b;
        logic [7:0] exp_b;
        int fetches;
        do_reset(); pulse_fs(); pulse_ls(3);
        fetches = 0;
        if (fetch === 1'b1) fetches++;
        serve(8'h01);
        for (int c = 0; c < 34; c++) begin
            b = 8'h00;
            for (int i = 0; i < 8; i++) begin
                pen = 1'b1;
                vdata = 8'h01;
                vdv = fetch;
                if (fetch === 1'b1) fetches++;
                tick();
                b = {b[6:0], pix};
            end
            exp_b = (c < 32) ? 8'h08 : 8'h00;
            checks++; if (b !== exp_b) begin errors++; $display("FAIL line_cell%0d got %h exp %h", c, b, exp_b); end
        end
        pen = 1'b0; vdv = 1'b0;
        checks++; if (fetches != 32) begin errors++; $display("FAIL line_fetches got %0d exp 32", fetches); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL line_underrun got %b exp 0", underrun); end
    endtask

    task automatic test_mid_line_start();
        logic [7:0] b;
        do_reset(); pulse_fs(); pulse_ls(3);
        serve(8'h01);
        for (int i = 0; i < 5; i++) begin
            pen = 1'b1; tick();
        end
        pen = 1'b0;
        checks++; if (pix !== 1'b1) begin errors++; $display("FAIL mid_pre_pixel got %b exp 1", pix); end
        pulse_ls(1);
        checks++; if (pix !== 1'b0) begin errors++; $display("FAIL mid_pixel got %b exp 0", pix); end
        checks++; if (fetch !== 1'b1) begin errors++; $display("FAIL mid_fetch got %b exp 1", fetch); end
        serve(8'h02); grab(b);
        checks++; if (b !== 8'h3C) begin errors++; $display("FAIL mid_next_cell got %h exp 3c", b); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        do_reset(); pulse_fs(); pulse_ls(3);
        ls = 1'b1; pen = 1'b1; vdv = 1'b1; vdata = 8'h02;
        tick();
        ls = 1'b0; pen = 1'b0; vdv = 1'b0;
        checks++; if (fetch !== 1'b1) begin errors++; $display("FAIL b2b_fetch got %b exp 1", fetch); end
        checks++; if (pix !== 1'b0) begin errors++; $display("FAIL b2b_pixel got %b exp 0", pix); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL b2b_underrun got %b exp 0", underrun); end
        checks++; if (romrow !== 4'd1) begin errors++; $display("FAIL b2b_row got %0d exp 1", romrow); end
        serve(8'h01); grab(b);
        checks++; if (b !== 8'h08) begin errors++; $display("FAIL b2b_cell got %h exp 08", b); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL b2b_underrun2 got %b exp 0", underrun); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_inverse();
        test_wrap();
        test_underrun();
        test_full_line();
        test_mid_line_start();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
